// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and reader state encoding for the FIR memory path
package fir_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 8;
  localparam int MEM_DEPTH  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } rd_state_e;

endpackage

// File: rtl/fir_skid_fifo.sv
// rtl/fir_skid_fifo.sv - 2-entry stream FIFO with head register and occupancy count
module fir_skid_fifo #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         pop_eff, push_eff;

  // pops on empty and pushes into a full FIFO without a pop are dropped
  assign pop_eff  = pop_i && (count_q != 2'd0);
  assign push_eff = push_i && ((count_q != 2'd2) || pop_eff);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push_eff, pop_eff})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_data_i;
        else                 tail_d = push_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          head_d = tail_q;
          tail_d = push_data_i;
        end else begin
          head_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = head_q;

endmodule

// File: rtl/fir_result_reader.sv
// rtl/fir_result_reader.sv - streams FIR results out of the sample/result memory
module fir_result_reader
  import fir_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              inflight_q, inflight_last_q;

  logic [1:0]        fifo_count;
  logic [DATA_W:0]   fifo_head;
  logic [1:0]        occupancy;
  logic              pop, issue, issue_last;

  assign m_valid   = (fifo_count != 2'd0);
  assign m_data    = fifo_head[DATA_W-1:0];
  assign m_last    = m_valid && fifo_head[DATA_W];
  assign pop       = m_valid && m_ready;

  // a pop this cycle frees the slot the new read will land in two cycles later
  assign occupancy  = fifo_count + {1'b0, inflight_q};
  assign issue      = (state_q == ST_READ) && ((occupancy < 2'd2) || pop);
  assign issue_last = ((rd_cnt_q + LEN_W'(1)) == len_q);

  assign mem_en   = issue;
  assign mem_addr = addr_q;
  assign busy     = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);

  // the last-beat tag travels with the data so m_last needs no beat counter
  fir_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, mem_data}),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          len_d    = length;
          rd_cnt_d = '0;
          state_d  = (length == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (issue) begin
          addr_d   = addr_q + ADDR_W'(1);
          rd_cnt_d = rd_cnt_q + LEN_W'(1);
          if (issue_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && m_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      rd_cnt_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      rd_cnt_q        <= rd_cnt_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && issue_last;
    end
  end

endmodule

// File: tb/tb_fir_result_reader.sv
// tb/tb_fir_result_reader.sv - directed self-checking bench for fir_result_reader
module tb_fir_result_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] length = '0;
  logic        mem_en;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic        busy;
  logic        done;

  logic [7:0]  mem [1024];
  int          total  = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) mem_data <= mem[mem_addr];
  end

  fir_result_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start a read-out and follow it to done, checking data, addresses, credit and stalls
  task automatic run_stream(input logic [9:0] base, input logic [10:0] len,
                            input bit toggle, input int inject_at);
    int          cyc;
    int          beats;
    int          issued;
    bit          got_done;
    bit          stalled;
    logic [7:0]  prev_data;
    logic        prev_last;
    logic [9:0]  exp_addr;
    bit          pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    start = 1'b1; base_addr = base; length = len;
    tick();
    start = 1'b0;
    cyc = 1; beats = 0; issued = 0; got_done = 1'b0; stalled = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    while (cyc < 200 && !got_done) begin
      m_ready = toggle ? pat[(cyc - 1) % 4] : 1'b1;
      if (cyc == inject_at) begin
        start = 1'b1; base_addr = 10'd100; length = 11'd5;
      end else begin
        start = 1'b0;
      end
      #1;
      if (done) begin
        got_done = 1'b1;
        check("done_busy", busy, 1'b0);
        check("done_valid", m_valid, 1'b0);
      end else begin
        check("busy", busy, 1'b1);
      end
      if (mem_en) begin
        exp_addr = base + 10'(issued);
        check("mem_addr", mem_addr, exp_addr);
        issued++;
      end
      if (stalled) begin
        check("stall_valid", m_valid, 1'b1);
        check("stall_data", m_data, prev_data);
        check("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        exp_addr = base + 10'(beats);
        check("beat_data", m_data, mem[exp_addr]);
        check("beat_last", m_last, (beats == int'(len) - 1));
        beats++;
      end
      check("credit", (issued - beats) <= 2, 1'b1);
      stalled   = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      tick();
      cyc++;
    end
    start = 1'b0;
    m_ready = 1'b1;
    check("stream_done_seen", got_done, 1'b1);
    check("stream_beats", beats, len);
    check("stream_reads", issued, len);
  endtask

  initial begin
    logic [7:0] exp_byte;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem[i] = 8'h40 + 8'(i);
    mem[1022] = 8'hAA; mem[1023] = 8'hBB;

    // reset state
    tick(); tick();
    check("rst_valid", m_valid, 1'b0);
    check("rst_last", m_last, 1'b0);
    check("rst_data", m_data, 8'h00);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_addr", mem_addr, 10'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b1;
    tick();

    // full-rate stream with exact cycle timing
    start = 1'b1; base_addr = 10'd0; length = 11'd8; m_ready = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      tick();
      start = 1'b0;
      #1;
      exp_byte = 8'h40 + 8'(n - 3);
      check("t1_busy", busy, (n <= 10));
      check("t1_done", done, (n == 11));
      check("t1_mem_en", mem_en, (n <= 8));
      if (n <= 8) check("t1_mem_addr", mem_addr, 10'(n - 1));
      check("t1_valid", m_valid, (n >= 3 && n <= 10));
      if (n >= 3 && n <= 10) check("t1_data", m_data, exp_byte);
      check("t1_last", m_last, (n == 10));
    end
    tick();
    check("t1_done_pulse", done, 1'b0);

    // backpressure with ready pattern 1,0,0,1
    run_stream(10'd0, 11'd8, 1'b1, 0);
    tick();

    // address wrap 1022 -> 1
    mem[0] = 8'hCC; mem[1] = 8'hDD;
    run_stream(10'd1022, 11'd4, 1'b0, 0);
    mem[0] = 8'h40; mem[1] = 8'h41;
    tick();

    // zero length
    start = 1'b1; base_addr = 10'd5; length = 11'd0;
    tick();
    start = 1'b0;
    #1;
    check("z_done", done, 1'b1);
    check("z_busy", busy, 1'b0);
    check("z_mem_en", mem_en, 1'b0);
    check("z_valid", m_valid, 1'b0);
    tick();
    check("z_done_end", done, 1'b0);
    check("z_valid_end", m_valid, 1'b0);

    // start mid-stream is ignored
    run_stream(10'd0, 11'd8, 1'b0, 3);
    tick();
    check("inj_idle_busy", busy, 1'b0);

    // reset during beat 3 of 8
    start = 1'b1; base_addr = 10'd0; length = 11'd8;
    tick();
    start = 1'b0;
    for (int n = 2; n <= 6; n++) tick();
    check("r_beat3", m_data, 8'h43);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("r_valid", m_valid, 1'b0);
    check("r_last", m_last, 1'b0);
    check("r_data", m_data, 8'h00);
    check("r_mem_en", mem_en, 1'b0);
    check("r_mem_addr", mem_addr, 10'd0);
    check("r_busy", busy, 1'b0);
    check("r_done", done, 1'b0);
    for (int n = 0; n < 3; n++) begin
      tick();
      check("r_quiet_valid", m_valid, 1'b0);
      check("r_quiet_done", done, 1'b0);
    end
    run_stream(10'd0, 11'd2, 1'b0, 0);

    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
